buyruk_onbellegi: RTL and testbench

Direct-mapped instruction cache that answers the fetch stage's instruction requests. It sits between fetch (request: `bellek_istek`/`bellek_ps`; response: `bellek_gecerli`/`bellek_deger`) and the main-memory read port. On a hit it returns the 32-bit instruction word one cycle after the request. On a miss it performs a 4-beat line refill from main memory, then responds.

---
 rtl/buyruk_onbellegi_pkg.sv | 10 +
 rtl/buyruk_onbellegi_veri.sv | 45 ++++
 rtl/buyruk_onbellegi.sv | 144 ++++++++++++++
 tb/tb_buyruk_onbellegi.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/buyruk_onbellegi_pkg.sv
// onbellek_paket: controller state encoding and default address-field widths for buyruk_onbellegi
package onbellek_paket;

    typedef enum logic [1:0] {BOSTA, ISTEK, DOLDUR, YANIT} durum_t;

    localparam int OFS_W    = 4;
    localparam int IDX_W    = 6;
    localparam int ETIKET_W = 32 - IDX_W - OFS_W;

endpackage

// File: rtl/buyruk_onbellegi_veri.sv
// onbellek_veri_dizisi: valid/tag/data storage with a combinational read port and a single refill write port
module onbellek_veri_dizisi
    import onbellek_paket::*;
#(
    parameter int SATIR_SAYISI   = 2 ** IDX_W,
    parameter int SATIR_KELIME   = 2 ** (OFS_W - 2),
    parameter int ETIKET_GENISLIK = ETIKET_W
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [$clog2(SATIR_SAYISI)-1:0]     oku_idx_i,
    output logic                                oku_gecerli_o,
    output logic [ETIKET_GENISLIK-1:0]          oku_etiket_o,
    output logic [SATIR_KELIME-1:0][31:0]       oku_satir_o,
    input  logic                                yaz_en_i,
    input  logic [$clog2(SATIR_SAYISI)-1:0]     yaz_idx_i,
    input  logic [$clog2(SATIR_KELIME)-1:0]     yaz_kelime_i,
    input  logic [31:0]                         yaz_veri_i,
    input  logic                                etiket_yaz_i,
    input  logic                                gecerli_yap_i,
    input  logic [ETIKET_GENISLIK-1:0]          etiket_i,
    input  logic                                temizle_i
);

    logic [SATIR_KELIME-1:0][31:0] veri_q [SATIR_SAYISI];
    logic [ETIKET_GENISLIK-1:0]    etiket_q [SATIR_SAYISI];
    logic [SATIR_SAYISI-1:0]       gecerli_q;

    assign oku_gecerli_o = gecerli_q[oku_idx_i];
    assign oku_etiket_o  = etiket_q[oku_idx_i];
    assign oku_satir_o   = veri_q[oku_idx_i];

    // Data words and tags are left unreset; only the valid bits gate their use
    always_ff @(posedge clk_i) begin
        if (yaz_en_i) veri_q[yaz_idx_i][yaz_kelime_i] <= yaz_veri_i;
        if (etiket_yaz_i) etiket_q[yaz_idx_i] <= etiket_i;
    end

    // Valid bits: reset and flush clear every line at once, flush wins over a same-cycle set
    always_ff @(posedge clk_i) begin
        if (rst_i || temizle_i) gecerli_q <= '0;
        else if (gecerli_yap_i) gecerli_q[yaz_idx_i] <= 1'b1;
    end

endmodule

// File: rtl/buyruk_onbellegi.sv
// buyruk_onbellegi: direct-mapped instruction cache with 4-beat line refill; BUYRUK_ONBELLEK_SAYAC_EN adds hit/miss counters
module buyruk_onbellegi
    import onbellek_paket::*;
#(
    parameter int SATIR_SAYISI = 2 ** IDX_W,
    parameter int SATIR_KELIME = 2 ** (OFS_W - 2)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bellek_istek_i,
    input  logic [31:0] bellek_ps_i,
    output logic        bellek_gecerli_o,
    output logic [31:0] bellek_deger_o,
    input  logic        temizle_i,
    output logic        ana_bellek_istek_o,
    output logic [31:0] ana_bellek_adres_o,
    input  logic        ana_bellek_hazir_i,
    input  logic        ana_bellek_gecerli_i,
    input  logic [31:0] ana_bellek_veri_i
`ifdef BUYRUK_ONBELLEK_SAYAC_EN
    ,
    output logic [31:0] isabet_sayac_o,
    output logic [31:0] iskalama_sayac_o
`endif
);

    localparam int KW = $clog2(SATIR_KELIME);
    localparam int IW = $clog2(SATIR_SAYISI);
    localparam int OW = KW + 2;
    localparam int TW = 32 - IW - OW;

    durum_t                  durum_q;
    logic [31:2]             ps_q;
    logic [KW-1:0]           sayac_q;
    logic                    bekliyor_q, gecerli_q, istek_q;
    logic [31:0]             deger_q, adres_q;
    logic [IW-1:0]           oku_idx;
    logic                    oku_gecerli, isabet, kabul, yaz_en, son_beat;
    logic [TW-1:0]           oku_etiket;
    logic [SATIR_KELIME-1:0][31:0] oku_satir;
    logic                    unused_ok;

    assign unused_ok = ^bellek_ps_i[1:0];

    // Idle looks up the incoming address; every other state reads the line being refilled
    assign oku_idx  = (durum_q == BOSTA) ? bellek_ps_i[OW +: IW] : ps_q[OW +: IW];
    assign isabet   = oku_gecerli && oku_etiket == bellek_ps_i[31 -: TW];
    assign kabul    = durum_q == BOSTA && bellek_istek_i && !temizle_i;
    assign yaz_en   = durum_q == DOLDUR && ana_bellek_gecerli_i;
    assign son_beat = yaz_en && sayac_q == KW'(SATIR_KELIME - 1);

    onbellek_veri_dizisi #(
        .SATIR_SAYISI    (SATIR_SAYISI),
        .SATIR_KELIME    (SATIR_KELIME),
        .ETIKET_GENISLIK (TW)
    ) u_dizi (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .oku_idx_i     (oku_idx),
        .oku_gecerli_o (oku_gecerli),
        .oku_etiket_o  (oku_etiket),
        .oku_satir_o   (oku_satir),
        .yaz_en_i      (yaz_en),
        .yaz_idx_i     (ps_q[OW +: IW]),
        .yaz_kelime_i  (sayac_q),
        .yaz_veri_i    (ana_bellek_veri_i),
        .etiket_yaz_i  (son_beat),
        .gecerli_yap_i (son_beat && !bekliyor_q && !temizle_i),
        .etiket_i      (ps_q[31 -: TW]),
        .temizle_i     (temizle_i)
    );

    // Lookup / refill controller with registered response and memory-request outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q    <= BOSTA;
            ps_q       <= '0;
            sayac_q    <= '0;
            bekliyor_q <= 1'b0;
            gecerli_q  <= 1'b0;
            deger_q    <= '0;
            istek_q    <= 1'b0;
            adres_q    <= '0;
        end else begin
            gecerli_q <= 1'b0;
            case (durum_q)
                BOSTA: if (kabul) begin
                    if (isabet) begin
                        gecerli_q <= 1'b1;
                        deger_q   <= oku_satir[bellek_ps_i[2 +: KW]];
                    end else begin
                        ps_q    <= bellek_ps_i[31:2];
                        istek_q <= 1'b1;
                        adres_q <= {bellek_ps_i[31:OW], OW'(0)};
                        durum_q <= ISTEK;
                    end
                end
                ISTEK: begin
                    if (temizle_i) bekliyor_q <= 1'b1;
                    if (ana_bellek_hazir_i) begin
                        istek_q <= 1'b0;
                        sayac_q <= '0;
                        durum_q <= DOLDUR;
                    end
                end
                DOLDUR: begin
                    if (temizle_i) bekliyor_q <= 1'b1;
                    if (yaz_en) sayac_q <= sayac_q + 1'b1;
                    if (son_beat) durum_q <= YANIT;
                end
                YANIT: begin
                    gecerli_q  <= 1'b1;
                    deger_q    <= oku_satir[ps_q[2 +: KW]];
                    bekliyor_q <= 1'b0;
                    durum_q    <= BOSTA;
                end
            endcase
        end
    end

    assign bellek_gecerli_o   = gecerli_q;
    assign bellek_deger_o     = deger_q;
    assign ana_bellek_istek_o = istek_q;
    assign ana_bellek_adres_o = adres_q;

`ifdef BUYRUK_ONBELLEK_SAYAC_EN
    logic [31:0] isabet_q, iskalama_q;

    // Hit and miss statistics; survive flushes, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            isabet_q   <= '0;
            iskalama_q <= '0;
        end else begin
            if (kabul && isabet) isabet_q <= isabet_q + 1'b1;
            if (kabul && !isabet) iskalama_q <= iskalama_q + 1'b1;
        end
    end

    assign isabet_sayac_o   = isabet_q;
    assign iskalama_sayac_o = iskalama_q;
`endif

endmodule

// File: tb/tb_buyruk_onbellegi.sv
// tb_buyruk_onbellegi: randomized scoreboard bench for buyruk_onbellegi with a behavioural cache/memory model
module tb_buyruk_onbellegi;

    logic        clk = 0, rst = 1, istek = 0, temizle = 0, hazir = 0, agec = 0;
    logic [31:0] ps = 0, averi = 0;
    logic        gecerli_o, aistek_o;
    logic [31:0] deger_o, adres_o;
`ifdef BUYRUK_ONBELLEK_SAYAC_EN
    logic [31:0] isabet, iskalama;
`endif

    int          vectors = 0, fails = 0;
    logic [31:0] exp_q[$], adr_q[$];
    bit          mv[64];
    logic [21:0] mt[64];
    int          m_hit = 0, m_miss = 0;
    int          beat = 0;
    bit          doldur = 0;

    always #5 clk = ~clk;

    buyruk_onbellegi dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .bellek_istek_i       (istek),
        .bellek_ps_i          (ps),
        .bellek_gecerli_o     (gecerli_o),
        .bellek_deger_o       (deger_o),
        .temizle_i            (temizle),
        .ana_bellek_istek_o   (aistek_o),
        .ana_bellek_adres_o   (adres_o),
        .ana_bellek_hazir_i   (hazir),
        .ana_bellek_gecerli_i (agec),
        .ana_bellek_veri_i    (averi)
`ifdef BUYRUK_ONBELLEK_SAYAC_EN
        ,
        .isabet_sayac_o       (isabet),
        .iskalama_sayac_o     (iskalama)
`endif
    );

    // Main-memory contents: line 0x100 holds 0xA0..0xA3, everything else a scrambled pattern
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a[31:4] == 28'h10) return 32'hA0 + 32'(a[3:2]);
        return (a & ~32'h3) * 32'h9E3779B1 + 32'h1234567;
    endfunction

    task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        return mv[a[9:4]] && mt[a[9:4]] == a[31:10];
    endfunction

    // Issue one fetch, hold it until answered; optionally flush once the refill has been accepted
    task automatic req(input logic [31:0] a, input bit flush_mid);
        int cyc = 0;
        bit hit, saw = 0, done = 0;
        hit = model_hit(a);
        exp_q.push_back(mem(a));
        if (hit) m_hit++;
        else begin
            adr_q.push_back({a[31:4], 4'h0});
            mv[a[9:4]] = 1;
            mt[a[9:4]] = a[31:10];
            m_miss++;
        end
        istek = 1;
        ps = a;
        do begin
            @(posedge clk); #2;
            cyc++;
            temizle = 0;
            if (aistek_o) saw = 1;
            if (flush_mid && saw && !aistek_o && !done) begin
                temizle = 1;
                done = 1;
                mv = '{default: 0};
            end
        end while (!gecerli_o && cyc < 300);
        temizle = 0;
        if (!gecerli_o) begin
            vectors++;
            fails++;
            $display("FAIL response_timeout: no response for %h after %0d cycles", a, cyc);
        end else if (hit) check("hit_latency", 32'(cyc), 32'd1);
        else check("miss_latency_at_least_7", 32'(cyc >= 7), 32'd1);
    endtask

    // Response monitor: every pulse must match the oldest outstanding expectation
    initial forever begin
        @(posedge clk); #1;
        if (gecerli_o) begin
            if (exp_q.size() == 0) begin
                vectors++;
                fails++;
                $display("FAIL spurious_response: got %h with nothing outstanding", deger_o);
            end else check("response_data", deger_o, exp_q.pop_front());
        end
    end

    // Main-memory responder: random accept delay, gapped ascending beats, stray beats while idle
    initial begin
        bit hs;
        bit istek_seen = 0;
        logic [31:0] adres_seen = 0, base = 0;
        forever begin
            @(posedge clk); #1;
            hs = hazir && istek_seen && !rst;
            hazir = 0;
            agec = 0;
            if (rst) doldur = 0;
            if (hs) begin
                if (adr_q.size() == 0) begin
                    vectors++;
                    fails++;
                    $display("FAIL unexpected_refill: address %h", adres_seen);
                end else check("refill_addr", adres_seen, adr_q.pop_front());
                doldur = 1;
                beat = 0;
                base = adres_seen;
            end
            if (doldur) begin
                if ($urandom_range(0, 3) != 0) begin
                    agec = 1;
                    averi = mem(base + 32'(beat * 4));
                    beat++;
                    if (beat == 4) doldur = 0;
                end
            end else if (!rst) begin
                agec = ($urandom_range(0, 7) == 0);
                averi = $urandom;
                if (aistek_o) hazir = 1'($urandom_range(0, 1));
            end
            istek_seen = aistek_o;
            adres_seen = adres_o;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [31:0] a;
        repeat (3) @(posedge clk);
        #2;
        check("rst_gecerli", 32'(gecerli_o), 32'd0);
        check("rst_deger", deger_o, 32'd0);
        check("rst_ana_istek", 32'(aistek_o), 32'd0);
        check("rst_ana_adres", adres_o, 32'd0);
        rst = 0;
        @(posedge clk); #2;

        req(32'h100, 0);
        istek = 0;
        @(posedge clk); #2;
        req(32'h104, 0);
        istek = 0;
        @(posedge clk); #2;

        for (int i = 0; i < 4; i++) req(32'h100 + 32'(i * 4), 0);
        istek = 0;
        @(posedge clk); #2;

        req(32'h500, 0);
        req(32'h100, 0);
        istek = 0;
        @(posedge clk); #2;

        req(32'h200, 1);
        istek = 0;
        @(posedge clk); #2;
        req(32'h200, 0);
        istek = 0;
        @(posedge clk); #2;

        exp_q.push_back(mem(32'h300));
        adr_q.push_back(32'h300);
        m_miss++;
        istek = 1;
        ps = 32'h300;
        cyc = 0;
        do begin
            @(posedge clk); #2;
            cyc++;
        end while (!(doldur && beat == 2) && cyc < 200);
        if (cyc >= 200) begin
            vectors++;
            fails++;
            $display("FAIL refill_beats_timeout: beat count %0d", beat);
        end
        rst = 1;
        istek = 0;
        @(posedge clk); #2;
        rst = 0;
        void'(exp_q.pop_back());
        mv = '{default: 0};
        m_hit = 0;
        m_miss = 0;
        check("rst_mid_ana_istek", 32'(aistek_o), 32'd0);
        repeat (8) @(posedge clk);
        #2;
        req(32'h300, 0);
        istek = 0;
        @(posedge clk); #2;

        istek = 1;
        ps = 32'h300;
        temizle = 1;
        @(posedge clk); #2;
        temizle = 0;
        mv = '{default: 0};
        check("flush_blocks_request", 32'(gecerli_o), 32'd0);
        req(32'h300, 0);
        istek = 0;
        @(posedge clk); #2;

        for (int i = 0; i < 300; i++) begin
            a = {20'h0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00};
            req(a, !model_hit(a) && $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) begin
                istek = 0;
                if ($urandom_range(0, 3) == 0) begin
                    temizle = 1;
                    mv = '{default: 0};
                end
                @(posedge clk); #2;
                temizle = 0;
            end
        end
        istek = 0;
        repeat (20) @(posedge clk);
        #2;
        check("outstanding_responses", 32'(exp_q.size()), 32'd0);
        check("outstanding_refills", 32'(adr_q.size()), 32'd0);
`ifdef BUYRUK_ONBELLEK_SAYAC_EN
        check("isabet_sayac", isabet, 32'(m_hit));
        check("iskalama_sayac", iskalama, 32'(m_miss));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
